mi_phy_rr_arbiter: RTL and testbench
====================================

# mi_phy_rr_arbiter

Round-robin arbiter that shares one MI slave bus between `PORTS` MI masters. In the network module it merges per-channel PHY/PMD management requesters onto the single `mi_phy` bus of the Ethernet core. It tracks outstanding reads in an ordered ID queue so that each `DRDY` and its `DRD` are returned to the master that issued the read. An optional watchdog completes reads the slave never answers.

## Interface
Parameters:
- `PORTS`, 4: number of MI masters, range 2 to 16.
- `DATA_WIDTH`, 32: MI data width.
- `ADDR_WIDTH`, 32: MI address width.
- `MAX_OUTSTANDING`, 8: depth of the read ID queue; must be a power of two.
- `TIMEOUT`, 1024: read watchdog limit in cycles. Used only with `MI_ARB_TIMEOUT_EN`.

Ports:
- `CLK`  in  1  single clock for the whole block.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `M_DWR`  in  `PORTS*DATA_WIDTH`  per-master write data.
- `M_ADDR`  in  `PORTS*ADDR_WIDTH`  per-master address.
- `M_BE`  in  `PORTS*DATA_WIDTH/8`  per-master byte enables.
- `M_RD`, `M_WR`  in  `PORTS`  per-master read / write request.
- `M_ARDY`  out  `PORTS`  per-master request accepted.
- `M_DRD`  out  `DATA_WIDTH`  read data, broadcast to all masters.
- `M_DRDY`  out  `PORTS`  per-master read data valid.
- `S_DWR`, `S_ADDR`, `S_BE`, `S_RD`, `S_WR`  out  widths as above  slave request.
- `S_ARDY`  in  1  slave accepts request.
- `S_DRD`  in  `DATA_WIDTH`  slave read data.
- `S_DRDY`  in  1  slave read data valid.
- `UNEXP_ERR`  out  1  one-cycle pulse: `S_DRDY` arrived while the queue was empty.
- `TIMEOUT_ERR`  out  1  one-cycle pulse: a read was completed by the watchdog.

## Operation
Grant state:
- States are `IDLE` and `BUSY(g)`, where `g` is the registered index of the granted master.
- `req_i = M_RD[i] | M_WR[i]`. A master holds its request stable until it sees `ARDY`.
- `IDLE`: if any `req_i` is high, go to `BUSY(w)`. The winner `w` is the first requesting port at or after `ptr`, scanning with wrap-around.
- `BUSY(g)`:
  - The slave request signals are a combinational mux of master `g`.
  - `S_RD = M_RD[g] & !q_full`. `S_WR = M_WR[g]`.
  - `M_ARDY[g] = S_ARDY & (S_RD | S_WR)`. All other `M_ARDY` bits are 0.
- Acceptance (`S_ARDY` with `S_RD` or `S_WR` high):
  - `ptr <= g+1` (mod `PORTS`).
  - Re-arbitrate in the same cycle over the other ports only; `req_g` is masked.
  - If another port wins, go to `BUSY(w)`, giving back-to-back transfers. Otherwise go to `IDLE`.
- If `req_g` drops without acceptance (a protocol violation), go to `IDLE` without moving `ptr`.

Read ID queue:
- An accepted read pushes `g`.
- `S_DRDY` pops the head `h` and drives `M_DRDY[h]=1`, `M_DRD=S_DRD`.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- `q_full` means count equals `MAX_OUTSTANDING`. While full, reads stall; writes still pass.
- `S_DRDY` with an empty queue: nothing is routed and `UNEXP_ERR` pulses.
- Count width is `log2(MAX_OUTSTANDING)+1`. Read and write pointers wrap modulo `MAX_OUTSTANDING`.

Reset:
- Asynchronous reset mid-operation clears state, `ptr`, the queue and the watchdog.
- Reads outstanding at reset are lost. Their later responses raise `UNEXP_ERR`.

## Timing
- Reset values:
  - All `M_ARDY`, `M_DRDY`, `S_RD`, `S_WR`, `UNEXP_ERR` and `TIMEOUT_ERR` are 0.
  - `S_DWR`, `S_ADDR`, `S_BE` and `M_DRD` are all zeros.
  - State is `IDLE`, `ptr=0`, queue empty.
- The first request from `IDLE` reaches the slave 1 cycle after it is asserted.
- Back-to-back requests from different ports have no bubble. A lone repeating port sees 1 idle cycle between requests.
- Read return is combinational: `M_DRDY` and `M_DRD` appear in the same cycle as `S_DRDY`.
- Both error outputs are registered pulses, asserted 1 cycle after the triggering event.

## Configuration
- `MI_ARB_TIMEOUT_EN` defined:
  - A watchdog counter runs while the queue is non-empty and `S_DRDY` is 0. It resets on every `S_DRDY` and every pop.
  - When it reaches `TIMEOUT`, the head is popped and `M_DRDY[h]` is driven 1 for one cycle with `M_DRD` all ones. `TIMEOUT_ERR` pulses.
  - If `S_DRDY` arrives in the expiry cycle, the real response wins and there is no timeout.
  - A slave response to a read that already timed out is a system error.
- `MI_ARB_TIMEOUT_EN` not defined: no watchdog counter is built and `TIMEOUT_ERR` is tied to 0.

## Test plan
- Ports 0 and 2 hold writes from reset, `S_ARDY=1` -> grants 0 then 2 in consecutive cycles, first `S_WR` on cycle 1, then `ptr=3`.
- All 4 ports hold reads repeatedly, slave answers 1 cycle after accept -> grant order 0,1,2,3,0..., each `M_DRD` value returned to its issuer in issue order.
- 9 reads with no `S_DRDY`, `MAX_OUTSTANDING=8` -> 8 accepted, the 9th stalls with `S_RD=0`; a concurrent write from another port is still accepted; one `S_DRDY` releases the 9th read.
- `S_DRDY` with the queue empty -> no `M_DRDY` bit set, `UNEXP_ERR` high for exactly 1 cycle.
- `RESET_N` asserted with 3 reads outstanding, then 3 `S_DRDY` -> no `M_DRDY`, 3 `UNEXP_ERR` pulses.
- With `MI_ARB_TIMEOUT_EN`, `TIMEOUT=16`, read from port 1 left unanswered -> 16 cycles after accept, `M_DRDY[1]=1` with `M_DRD=0xFFFFFFFF`, `TIMEOUT_ERR` pulse.

Source files
------------

// File: rtl/mi_phy_rr_arbiter.sv
// Round-robin arbiter sharing one MI slave bus between PORTS masters, with an ordered read-ID queue.
// Define MI_ARB_TIMEOUT_EN to build the read watchdog; otherwise TIMEOUT_ERR is tied to 0.
module mi_phy_rr_arbiter #(
  parameter int PORTS           = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT         = 1024
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic [PORTS*DATA_WIDTH-1:0]    M_DWR,
  input  logic [PORTS*ADDR_WIDTH-1:0]    M_ADDR,
  input  logic [PORTS*DATA_WIDTH/8-1:0]  M_BE,
  input  logic [PORTS-1:0]               M_RD,
  input  logic [PORTS-1:0]               M_WR,
  output logic [PORTS-1:0]               M_ARDY,
  output logic [DATA_WIDTH-1:0]          M_DRD,
  output logic [PORTS-1:0]               M_DRDY,
  output logic [DATA_WIDTH-1:0]          S_DWR,
  output logic [ADDR_WIDTH-1:0]          S_ADDR,
  output logic [DATA_WIDTH/8-1:0]        S_BE,
  output logic                           S_RD,
  output logic                           S_WR,
  input  logic                           S_ARDY,
  input  logic [DATA_WIDTH-1:0]          S_DRD,
  input  logic                           S_DRDY,
  output logic                           UNEXP_ERR,
  output logic                           TIMEOUT_ERR
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDW      = $clog2(PORTS);
  localparam int QAW      = $clog2(MAX_OUTSTANDING);
  localparam int CNTW     = QAW + 1;
  localparam logic [IDW:0]   PORTS_W   = (IDW+1)'(PORTS);
  localparam logic [IDW-1:0] LAST_PORT = IDW'(PORTS - 1);
  localparam logic [CNTW-1:0] Q_DEPTH  = CNTW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_mem_q [MAX_OUTSTANDING];
  logic [QAW-1:0]  wr_ptr_q;
  logic [QAW-1:0]  rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic            unexp_err_q;
  logic            timeout_err_q;

  logic [DATA_WIDTH-1:0] dwr_a  [PORTS];
  logic [ADDR_WIDTH-1:0] addr_a [PORTS];
  logic [BE_WIDTH-1:0]   be_a   [PORTS];

  logic [PORTS-1:0] req_s;
  logic [PORTS-1:0] grant_mask_s;
  logic [IDW-1:0]   nxt_ptr_s;
  logic [IDW:0]     idle_pick_s;
  logic [IDW:0]     rearb_pick_s;
  logic             busy_s;
  logic             q_full_s;
  logic             q_empty_s;
  logic             s_rd_s;
  logic             s_wr_s;
  logic             accept_s;
  logic             push_s;
  logic             drdy_pop_s;
  logic             expire_s;
  logic             pop_s;
  logic [IDW-1:0]   head_s;

  // First requesting port at or after start, with wrap-around; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [PORTS-1:0] req, input logic [IDW-1:0] start);
    logic [PORTS-1:0] rot;
    logic [IDW:0]     sum;
    logic [IDW:0]     res;
    rot = PORTS'({req, req} >> start);
    sum = '0;
    res = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start} + (IDW+1)'(k);
        if (sum >= PORTS_W) begin
          sum = sum - PORTS_W;
        end else begin
          sum = sum;
        end
        res = {1'b1, sum[IDW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign dwr_a[i]  = M_DWR[i*DATA_WIDTH +: DATA_WIDTH];
    assign addr_a[i] = M_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_a[i]   = M_BE[i*BE_WIDTH +: BE_WIDTH];
  end

  assign req_s        = M_RD | M_WR;
  assign busy_s       = (state_q == ST_BUSY);
  assign q_full_s     = (count_q == Q_DEPTH);
  assign q_empty_s    = (count_q == '0);
  assign s_rd_s       = busy_s & M_RD[grant_q] & ~q_full_s;
  assign s_wr_s       = busy_s & M_WR[grant_q];
  assign accept_s     = S_ARDY & (s_rd_s | s_wr_s);
  assign push_s       = accept_s & s_rd_s;
  assign head_s       = id_mem_q[rd_ptr_q];
  assign drdy_pop_s   = S_DRDY & ~q_empty_s;
  assign pop_s        = drdy_pop_s | expire_s;
  assign grant_mask_s = {{(PORTS-1){1'b0}}, 1'b1} << grant_q;
  assign nxt_ptr_s    = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
  assign idle_pick_s  = rr_pick(req_s, ptr_q);
  assign rearb_pick_s = rr_pick(req_s & ~grant_mask_s, nxt_ptr_s);

  assign S_RD        = s_rd_s;
  assign S_WR        = s_wr_s;
  assign UNEXP_ERR   = unexp_err_q;
  assign TIMEOUT_ERR = timeout_err_q;

  // Slave request mux and per-master accept/return routing.
  always_comb begin
    S_DWR  = '0;
    S_ADDR = '0;
    S_BE   = '0;
    M_ARDY = '0;
    M_DRDY = '0;
    M_DRD  = '0;
    if (busy_s) begin
      S_DWR  = dwr_a[grant_q];
      S_ADDR = addr_a[grant_q];
      S_BE   = be_a[grant_q];
    end else begin
      S_DWR  = '0;
    end
    if (accept_s) begin
      M_ARDY[grant_q] = 1'b1;
    end else begin
      M_ARDY = '0;
    end
    if (drdy_pop_s) begin
      M_DRDY[head_s] = 1'b1;
      M_DRD          = S_DRD;
    end else if (expire_s) begin
      M_DRDY[head_s] = 1'b1;
      M_DRD          = '1;
    end else begin
      M_DRD = '0;
    end
  end

  // Grant FSM: a stalled read keeps its grant; re-arbitration on accept skips the port just served.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idle_pick_s[IDW]) begin
            state_q <= ST_BUSY;
            grant_q <= idle_pick_s[IDW-1:0];
          end
        end
        ST_BUSY: begin
          if (accept_s) begin
            ptr_q <= nxt_ptr_s;
            if (rearb_pick_s[IDW]) begin
              grant_q <= rearb_pick_s[IDW-1:0];
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (!req_s[grant_q]) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Queue occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Read ID storage; entries beyond the pointers are don't-care so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      id_mem_q[wr_ptr_q] <= grant_q;
    end
  end

  // Queue pointers, occupancy and registered error pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      unexp_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      unexp_err_q   <= S_DRDY & q_empty_s;
      timeout_err_q <= expire_s;
    end
  end

`ifdef MI_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_d;

  // Expiry on the TIMEOUT-th unanswered cycle; a real S_DRDY in that cycle wins.
  assign expire_s = ~S_DRDY & ~q_empty_s & (wd_q == WDW'(TIMEOUT - 1));

  // Watchdog next-state: counts waiting cycles of the current head.
  always_comb begin
    wd_d = wd_q;
    if (q_empty_s || S_DRDY || pop_s) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  localparam int unused_timeout_p = TIMEOUT;
  assign expire_s = 1'b0;
`endif

endmodule

// File: tb/tb_mi_phy_rr_arbiter.sv
// Self-checking bench for mi_phy_rr_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the arbitration and read-return rules.
module tb_mi_phy_rr_arbiter;
  localparam int P    = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 8;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [P*DW-1:0] m_dwr;
  logic [P*AW-1:0] m_addr;
  logic [P*BW-1:0] m_be;
  logic [P-1:0]    m_rd, m_wr, m_ardy, m_drdy;
  logic [DW-1:0]   m_drd, s_dwr, s_drd;
  logic [AW-1:0]   s_addr;
  logic [BW-1:0]   s_be;
  logic            s_rd, s_wr, s_ardy, s_drdy, unexp_err, timeout_err;

  mi_phy_rr_arbiter #(
    .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RESET_N(rst_n),
    .M_DWR(m_dwr), .M_ADDR(m_addr), .M_BE(m_be), .M_RD(m_rd), .M_WR(m_wr),
    .M_ARDY(m_ardy), .M_DRD(m_drd), .M_DRDY(m_drdy),
    .S_DWR(s_dwr), .S_ADDR(s_addr), .S_BE(s_be), .S_RD(s_rd), .S_WR(s_wr),
    .S_ARDY(s_ardy), .S_DRD(s_drd), .S_DRDY(s_drdy),
    .UNEXP_ERR(unexp_err), .TIMEOUT_ERR(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit       busy_m;
  int       g_m, ptr_m, age_m;
  int       idq[$];
  int       acc_log[$];
  bit       unexp_m, to_m;
  logic [P-1:0] last_ardy;
  bit       last_push;

  // DUT values seen in the most recent step
  logic [P-1:0]  obs_ardy, obs_drdy;
  logic [DW-1:0] obs_drd;
  logic [AW-1:0] obs_addr;
  logic          obs_srd, obs_swr, obs_unexp, obs_to;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [P-1:0] req, input int start);
    for (int k = 0; k < P; k++) begin
      if (req[(start + k) % P]) return (start + k) % P;
    end
    return -1;
  endfunction

  task automatic model_reset();
    busy_m = 0; g_m = 0; ptr_m = 0; age_m = 0;
    idq.delete(); acc_log.delete();
    unexp_m = 0; to_m = 0; last_ardy = '0; last_push = 0;
  endtask

  // One clock cycle: check outputs at negedge against the model, then advance the model.
  task automatic step();
    logic [P-1:0]  req, mask, e_ardy, e_drdy;
    logic [DW-1:0] e_drd, e_dwr;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    bit full, e_srd, e_swr, acc, pop, expire;
    int w;
    @(negedge clk);
    req = m_rd | m_wr;
    full = (idq.size() == MAXO);
    e_srd = 0; e_swr = 0; e_addr = '0; e_dwr = '0; e_be = '0;
    if (busy_m) begin
      e_srd  = m_rd[g_m] && !full;
      e_swr  = m_wr[g_m];
      e_addr = m_addr[g_m*AW +: AW];
      e_dwr  = m_dwr[g_m*DW +: DW];
      e_be   = m_be[g_m*BW +: BW];
    end
    acc = busy_m && s_ardy && (e_srd || e_swr);
    e_ardy = '0;
    if (acc) e_ardy[g_m] = 1'b1;
    e_drdy = '0; e_drd = '0; pop = 0; expire = 0;
    if (s_drdy && idq.size() > 0) begin
      e_drdy[idq[0]] = 1'b1; e_drd = s_drd; pop = 1;
    end
`ifdef MI_ARB_TIMEOUT_EN
    else if (!s_drdy && idq.size() > 0 && age_m == TO - 1) begin
      e_drdy[idq[0]] = 1'b1; e_drd = '1; pop = 1; expire = 1;
    end
`endif
    obs_ardy = m_ardy; obs_drdy = m_drdy; obs_drd = m_drd; obs_addr = s_addr;
    obs_srd = s_rd; obs_swr = s_wr; obs_unexp = unexp_err; obs_to = timeout_err;
    check_eq("s_rd", s_rd, e_srd);
    check_eq("s_wr", s_wr, e_swr);
    check_eq("s_addr", s_addr, e_addr);
    check_eq("s_dwr", s_dwr, e_dwr);
    check_eq("s_be", s_be, e_be);
    check_eq("m_ardy", m_ardy, e_ardy);
    check_eq("m_drdy", m_drdy, e_drdy);
    check_eq("m_drd", m_drd, e_drd);
    check_eq("unexp_err", unexp_err, unexp_m);
    check_eq("timeout_err", timeout_err, to_m);
    unexp_m = s_drdy && idq.size() == 0;
    to_m = expire;
    if (pop || s_drdy || idq.size() == 0) age_m = 0;
    else age_m++;
    if (pop) void'(idq.pop_front());
    if (acc && e_srd) idq.push_back(g_m);
    if (acc) acc_log.push_back(g_m);
    if (busy_m) begin
      if (acc) begin
        ptr_m = (g_m + 1) % P;
        mask = '0; mask[g_m] = 1'b1;
        w = rr_winner(req & ~mask, ptr_m);
        if (w >= 0) g_m = w;
        else busy_m = 0;
      end else if (!req[g_m]) begin
        busy_m = 0;
      end
    end else begin
      w = rr_winner(req, ptr_m);
      if (w >= 0) begin busy_m = 1; g_m = w; end
    end
    last_ardy = e_ardy;
    last_push = acc && e_srd;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_rd = '0; m_wr = '0; s_ardy = 1'b0; s_drdy = 1'b0; s_drd = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Protocol-respecting masters: keep a request until accepted, then maybe issue a new one.
  task automatic refresh_masters(input int prob, input bit rd_only);
    bit kind;
    for (int i = 0; i < P; i++) begin
      if (last_ardy[i] || !(m_rd[i] || m_wr[i])) begin
        if (int'($urandom_range(99)) < prob) begin
          kind = rd_only ? 1'b1 : 1'($urandom_range(1));
          m_rd[i] = kind; m_wr[i] = !kind;
          m_addr[i*AW +: AW] = $urandom;
          m_dwr[i*DW +: DW]  = $urandom;
          m_be[i*BW +: BW]   = BW'($urandom);
        end else begin
          m_rd[i] = 1'b0; m_wr[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n0, n0b, n1, nd, nu, k;
    m_dwr = '0; m_addr = '0; m_be = '0; m_rd = '0; m_wr = '0;
    s_ardy = 1'b0; s_drdy = 1'b0; s_drd = '0; rst_n = 1'b0;
    model_reset();

    // reset values with requests present
    #12;
    m_rd = '1; m_addr = {P{32'hA5A5_0000}}; m_dwr = {P{32'h1234_5678}}; m_be = '1; s_ardy = 1'b1;
    #3;
    check_eq("rst_s_rd", s_rd, 1'b0);
    check_eq("rst_s_addr", s_addr, 32'h0);
    check_eq("rst_s_dwr", s_dwr, 32'h0);
    check_eq("rst_m_ardy", m_ardy, 4'b0);
    check_eq("rst_m_drd", m_drd, 32'h0);
    check_eq("rst_errs", {unexp_err, timeout_err}, 2'b00);
    do_reset();

    // two writers from reset: grants 0 then 2, then ptr=3 favours port 3 over 0
    m_wr = 4'b0101; m_addr[0 +: AW] = 32'h0000_1000; m_addr[2*AW +: AW] = 32'h0000_3000; s_ardy = 1'b1;
    step(); check_eq("t1_c0_swr", obs_swr, 1'b0);
    step(); check_eq("t1_c1_ardy", obs_ardy, 4'b0001); check_eq("t1_c1_addr", obs_addr, 32'h0000_1000);
    m_wr[0] = 1'b0;
    step(); check_eq("t1_c2_ardy", obs_ardy, 4'b0100); check_eq("t1_c2_addr", obs_addr, 32'h0000_3000);
    m_wr = 4'b1001;
    step(); step(); check_eq("t1_ptr3_ardy", obs_ardy, 4'b1000);
    m_wr[3] = 1'b0;
    step(); check_eq("t1_next_ardy", obs_ardy, 4'b0001);
    m_wr = '0; step();

    // all ports reading, slave answers one cycle after accept
    do_reset(); s_ardy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      refresh_masters(100, 1'b1);
      s_drdy = last_push; s_drd = $urandom;
      step();
    end
    for (int i = 0; i < 8; i++) check_eq("t2_order", acc_log[i], i % P);
    m_rd = '0; s_drdy = last_push; step(); s_drdy = 1'b0; step();

    // queue fill: 8 reads accepted, 9th stalls, a write from port 1 still passes
    do_reset(); s_ardy = 1'b1; m_rd[0] = 1'b1; n0 = 0;
    for (int c = 0; c < 40 && n0 < MAXO; c++) begin
      step(); if (obs_ardy[0]) begin n0++; m_addr[0 +: AW] = $urandom; end
    end
    check_eq("t3_reads_accepted", n0, MAXO);
    m_wr[1] = 1'b1; n0b = 0; n1 = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_ardy[0]) n0b++;
      if (obs_ardy[1]) begin n1++; m_wr[1] = 1'b0; end
    end
    check_eq("t3_write_passed", n1, 1);
    check_eq("t3_read_stalled", n0b, 0);
    check_eq("t3_stall_srd", obs_srd, 1'b0);
    s_drdy = 1'b1; s_drd = 32'hCAFE_0001; step(); s_drdy = 1'b0;
    check_eq("t3_pop_drdy", obs_drdy, 4'b0001);
    check_eq("t3_pop_drd", obs_drd, 32'hCAFE_0001);
    step(); check_eq("t3_release_ardy", obs_ardy, 4'b0001);
    m_rd = '0; step();

    // response with empty queue
    do_reset();
    s_drdy = 1'b1; s_drd = 32'hDEAD_BEEF; step(); s_drdy = 1'b0;
    check_eq("t4_no_drdy", obs_drdy, 4'b0000);
    step(); check_eq("t4_unexp_pulse", obs_unexp, 1'b1);
    step(); check_eq("t4_unexp_end", obs_unexp, 1'b0);

    // reset with 3 reads outstanding; their responses become unexpected
    do_reset(); s_ardy = 1'b1; m_rd = 4'b0111; n0 = 0;
    for (int c = 0; c < 10; c++) begin
      step(); n0 += $countones(obs_ardy); m_rd = m_rd & ~obs_ardy;
    end
    check_eq("t5_outstanding", n0, 3);
    do_reset(); nd = 0; nu = 0;
    for (int c = 0; c < 5; c++) begin
      s_drdy = (c < 3); s_drd = $urandom; step();
      if (obs_drdy != '0) nd++;
      if (obs_unexp) nu++;
    end
    s_drdy = 1'b0;
    check_eq("t5_no_drdy", nd, 0);
    check_eq("t5_unexp_count", nu, 3);

`ifdef MI_ARB_TIMEOUT_EN
    // unanswered read from port 1 is completed by the watchdog
    do_reset(); s_ardy = 1'b1; m_rd[1] = 1'b1;
    for (int c = 0; c < 10 && m_rd[1]; c++) begin
      step(); if (obs_ardy[1]) m_rd[1] = 1'b0;
    end
    k = 0;
    for (int c = 0; c < 40; c++) begin
      step(); k++;
      if (obs_drdy != '0) break;
    end
    check_eq("t6_timeout_cycles", k, TO);
    check_eq("t6_timeout_drdy", obs_drdy, 4'b0010);
    check_eq("t6_timeout_drd", obs_drd, 32'hFFFF_FFFF);
    step(); check_eq("t6_timeout_err", obs_to, 1'b1);
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      refresh_masters(60, 1'b0);
      s_ardy = ($urandom_range(3) != 0);
      if (idq.size() > 0) s_drdy = 1'($urandom_range(1));
      else s_drdy = ($urandom_range(19) == 0);
      s_drd = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
